write_pointer: RTL

//  Write-side controller of the synchronous FIFO used by the systolic array input/output buffers.
//  It is the producer-side counterpart to the FIFO read pointer.
//  - Gates producer write requests and advances the write address wptr.
//  - Tracks occupancy and generates fifo_empty (consumed by the read side) and fifo_full / almost_full.
//  - Flags overflow attempts and supports a one-cycle flush that discards all stored entries.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_occupancy.sv | 59 +++++
 rtl/write_pointer.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO write and read pointer controllers.
package fifo_pkg;

  // Write-side controller states.
  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } wr_state_t;

  // FIFO depth for a given address width, shared with the read side.
  function automatic int unsigned fifo_depth(input int unsigned ptr_length);
    return 32'd1 << ptr_length;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_occupancy.sv
// FIFO occupancy tracker: count register, next-count logic and level decodes.
module fifo_occupancy
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_LENGTH         = 5,
  parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_inc,
  input  logic                  i_dec,
  input  logic                  i_flush,
  output logic [PTR_LENGTH:0]   o_count,
  output logic                  o_almost_full,
  output logic                  o_next_full,
  output logic                  o_next_empty
);

  localparam logic [PTR_LENGTH:0] DEPTH    = (PTR_LENGTH+1)'(fifo_depth(PTR_LENGTH));
  localparam logic [PTR_LENGTH:0] AF_LEVEL =
    (PTR_LENGTH+1)'(fifo_depth(PTR_LENGTH) - ALMOST_FULL_MARGIN);
  localparam logic [PTR_LENGTH:0] ONE      = {{PTR_LENGTH{1'b0}}, 1'b1};

  logic [PTR_LENGTH:0] r_count;
  logic                r_almost_full;
  logic [PTR_LENGTH:0] w_next_count;

  // Next occupancy: flush, then balanced write+read, then write, then read (saturating at 0).
  always_comb begin
    w_next_count = r_count;
    if (i_flush) begin
      w_next_count = '0;
    end else if (i_inc && i_dec) begin
      w_next_count = r_count;
    end else if (i_inc) begin
      if (r_count != DEPTH) w_next_count = r_count + ONE;
    end else if (i_dec) begin
      if (r_count != '0) w_next_count = r_count - ONE;
    end
  end

  assign o_next_full  = (w_next_count == DEPTH);
  assign o_next_empty = (w_next_count == '0);

  // Occupancy and almost-full flag, registered from the next-count value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_count       <= w_next_count;
      r_almost_full <= (w_next_count >= AF_LEVEL);
    end
  end

  assign o_count       = r_count;
  assign o_almost_full = r_almost_full;

endmodule : fifo_occupancy

// File: rtl/write_pointer.sv
// Write-side controller of the synchronous FIFO: write gating, write address,
// occupancy-driven empty/full state machine and sticky overflow flag.
module write_pointer
  import fifo_pkg::*;
#(
  parameter int unsigned PTR_LENGTH         = 5,
  parameter int unsigned ALMOST_FULL_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  fifo_read,
  input  logic [PTR_LENGTH-1:0] rptr,
  input  logic                  flush,
  input  logic                  clear_overflow,
  output logic [PTR_LENGTH-1:0] wptr,
  output logic                  fifo_write,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic [PTR_LENGTH:0]   count,
  output logic                  overflow
);

  localparam logic [PTR_LENGTH-1:0] PTR_ONE = {{(PTR_LENGTH-1){1'b0}}, 1'b1};

  wr_state_t             r_state;
  logic [PTR_LENGTH-1:0] r_wptr;
  logic                  r_overflow;
  logic                  w_fifo_write;
  logic                  w_next_full;
  logic                  w_next_empty;

  // Full is the registered state, so a read in the full cycle cannot free the slot until next cycle.
  assign w_fifo_write = write & ~fifo_full & ~flush & ~reset;

  fifo_occupancy #(
    .PTR_LENGTH        (PTR_LENGTH),
    .ALMOST_FULL_MARGIN(ALMOST_FULL_MARGIN)
  ) u_occupancy (
    .clk          (clk),
    .reset        (reset),
    .i_inc        (w_fifo_write),
    .i_dec        (fifo_read),
    .i_flush      (flush),
    .o_count      (count),
    .o_almost_full(almost_full),
    .o_next_full  (w_next_full),
    .o_next_empty (w_next_empty)
  );

  // Write address: reload from the read address on flush, otherwise advance per accepted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
    end else if (flush) begin
      r_wptr <= rptr;
    end else if (w_fifo_write) begin
      r_wptr <= r_wptr + PTR_ONE;
    end
  end

  // Sticky overflow: a blocked write while full sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (write && fifo_full && !flush) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Empty/fill/full state machine steered by the next-count decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_fifo_write) r_state <= w_next_full ? ST_FULL : ST_FILL;
        end
        ST_FILL: begin
          if (w_next_full)       r_state <= ST_FULL;
          else if (w_next_empty) r_state <= ST_EMPTY;
        end
        ST_FULL: begin
          if (fifo_read && !w_next_full) r_state <= w_next_empty ? ST_EMPTY : ST_FILL;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign wptr       = r_wptr;
  assign fifo_write = w_fifo_write;
  assign fifo_full  = (r_state == ST_FULL);
  assign fifo_empty = (r_state == ST_EMPTY);
  assign overflow   = r_overflow;

endmodule : write_pointer
